mc_ctrl: RTL and testbench

//  Multi-cycle control FSM on the consuming side of the IFU fetch interface.
//  - Latches the fetched instruction and decodes it.
//  - Sequences datapath enables over FETCH/DECODE/EXEC/MEM/WB.
//  - Drives the IFU's npc_sel and PC write-enable, so the PC advances exactly once per retired instruction.
//  - Subset: addu subu jr ori lw sw beq lui j jal.

---
 rtl/mc_ctrl_pkg.sv | 98 +++++++++
 rtl/mc_ctrl_decode.sv | 40 ++++
 rtl/mc_ctrl.sv | 138 +++++++++++++
 tb/tb_mc_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: IFU next-PC selects, FSM states,
// datapath select codes, MIPS opcode/funct constants and the decoded instruction class.
package mc_ctrl_pkg;

    typedef enum logic [1:0] {
        IFU_SEL_NORM       = 2'd0,
        IFU_SEL_RELATIVE   = 2'd1,
        IFU_SEL_IRRELATIVE = 2'd2,
        IFU_SEL_REGISTER   = 2'd3
    } npc_sel_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [1:0] ALU_OP_ADD  = 2'd0;
    localparam logic [1:0] ALU_OP_SUB  = 2'd1;
    localparam logic [1:0] ALU_OP_OR   = 2'd2;
    localparam logic [1:0] EXT_ZERO    = 2'd0;
    localparam logic [1:0] EXT_SIGN    = 2'd1;
    localparam logic [1:0] EXT_LUI     = 2'd2;
    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_RA  = 2'd2;
    localparam logic [1:0] WD_SEL_ALU  = 2'd0;
    localparam logic [1:0] WD_SEL_MEM  = 2'd1;
    localparam logic [1:0] WD_SEL_PC4  = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef struct packed {
        logic rtype_alu;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic illegal;
    } inst_class_t;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src;
        logic [1:0] ext_op;
        logic [1:0] alu_op;
    } ctrl_sel_t;

    // Datapath selects depend only on the instruction, so they stay stable from DECODE to WB.
    function automatic ctrl_sel_t sel_for(inst_class_t c, logic is_sub);
        ctrl_sel_t s;
        s = '0;
        if (c.rtype_alu) begin
            s.reg_dst = REG_DST_RD;
            s.alu_op  = is_sub ? ALU_OP_SUB : ALU_OP_ADD;
        end
        if (c.ori) begin
            s.alu_src = 1'b1;
            s.ext_op  = EXT_ZERO;
            s.alu_op  = ALU_OP_OR;
        end
        if (c.lui) begin
            s.alu_src = 1'b1;
            s.ext_op  = EXT_LUI;
            s.alu_op  = ALU_OP_OR;
        end
        if (c.lw || c.sw) begin
            s.alu_src = 1'b1;
            s.ext_op  = EXT_SIGN;
            s.alu_op  = ALU_OP_ADD;
        end
        if (c.lw)  s.wd_sel = WD_SEL_MEM;
        if (c.beq) s.alu_op = ALU_OP_SUB;
        if (c.jal) begin
            s.reg_dst = REG_DST_RA;
            s.wd_sel  = WD_SEL_PC4;
        end
        return s;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decoder producing a one-hot instruction class.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [9:0]  cls_o
);

    inst_class_t c;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    assign opcode = inst_i[31:26];
    assign funct  = inst_i[5:0];

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU: c.rtype_alu = 1'b1;
                    FN_JR:            c.jr        = 1'b1;
                    default:          c.illegal   = 1'b1;
                endcase
            end
            OP_J:    c.j       = 1'b1;
            OP_JAL:  c.jal     = 1'b1;
            OP_BEQ:  c.beq     = 1'b1;
            OP_ORI:  c.ori     = 1'b1;
            OP_LUI:  c.lui     = 1'b1;
            OP_LW:   c.lw      = 1'b1;
            OP_SW:   c.sw      = 1'b1;
            default: c.illegal = 1'b1;
        endcase
    end

    assign cls_o = c;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller; owns IR, drives IFU PC update and
// datapath enables, and counts retired instructions.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int IW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IW-1:0]    inst,
    input  logic             zero,
    output logic [IW-1:0]    ir,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       npc_sel,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             alu_src,
    output logic [1:0]       ext_op,
    output logic [1:0]       alu_op,
    output logic             mem_we,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_e           state_q, state_d;
    logic [IW-1:0]    ir_q;
    logic [CNT_W-1:0] retired_q;
    inst_class_t      cls;
    ctrl_sel_t        sel;
    npc_sel_e         npc_d;
    logic             is_sub;

    mc_decode u_decode (
        .inst_i (ir_q[31:0]),
        .cls_o  (cls)
    );

    assign is_sub = (ir_q[5:0] == FN_SUBU);

    always_comb begin
        state_d = S_FETCH;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        npc_d   = IFU_SEL_NORM;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        illegal = 1'b0;
        sel     = '0;
        case (state_q)
            S_FETCH: begin
                ir_we   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                sel = sel_for(cls, is_sub);
                if (cls.j || cls.jal) begin
                    pc_we  = 1'b1;
                    npc_d  = IFU_SEL_IRRELATIVE;
                    reg_we = cls.jal;
                end else if (cls.jr) begin
                    pc_we = 1'b1;
                    npc_d = IFU_SEL_REGISTER;
                end else if (cls.illegal) begin
                    illegal = 1'b1;
                    pc_we   = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                sel = sel_for(cls, is_sub);
                if (cls.beq) begin
                    pc_we = 1'b1;
                    npc_d = zero ? IFU_SEL_RELATIVE : IFU_SEL_NORM;
                end else if (cls.lw || cls.sw) begin
                    state_d = S_MEM;
                end else if (cls.rtype_alu || cls.ori || cls.lui) begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                sel = sel_for(cls, is_sub);
                if (cls.sw) begin
                    mem_we = 1'b1;
                    pc_we  = 1'b1;
                end else if (cls.lw) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                sel    = sel_for(cls, is_sub);
                reg_we = 1'b1;
                pc_we  = 1'b1;
            end
            default: ;
        endcase
        // Reset abandons any in-flight instruction without committing anything.
        if (reset) begin
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            npc_d   = IFU_SEL_NORM;
            reg_we  = 1'b0;
            mem_we  = 1'b0;
            illegal = 1'b0;
            sel     = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (ir_we) ir_q <= inst;
            if (pc_we) retired_q <= retired_q + CNT_ONE;
        end
    end

    assign ir      = ir_q;
    assign npc_sel = npc_d;
    assign reg_dst = sel.reg_dst;
    assign wd_sel  = sel.wd_sel;
    assign alu_src = sel.alu_src;
    assign ext_op  = sel.ext_op;
    assign alu_op  = sel.alu_op;
    assign retired = retired_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: the driver queues the expected retirement of each fetched
// instruction; a negedge monitor pops one entry on every pc_we and compares it.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    localparam int CNT_W = 4;  // narrow counter so the wrap is reachable in a short run

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      inst;
    logic             zero;
    logic [31:0]      ir;
    logic             ir_we, pc_we, reg_we, mem_we, illegal, alu_src;
    logic [1:0]       npc_sel, reg_dst, wd_sel, ext_op, alu_op;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state_o;

    mc_ctrl #(.IW(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .inst(inst), .zero(zero), .ir(ir), .ir_we(ir_we),
        .pc_we(pc_we), .npc_sel(npc_sel), .reg_we(reg_we), .reg_dst(reg_dst),
        .wd_sel(wd_sel), .alu_src(alu_src), .ext_op(ext_op), .alu_op(alu_op),
        .mem_we(mem_we), .illegal(illegal), .retired(retired), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        z;
        int          lat;
        logic [1:0]  npc;
        logic        rw;
        logic [1:0]  rd;
        logic [1:0]  wd;
        logic        mw;
        logic        il;
        logic [1:0]  ao;
        logic        ao_dc;
        logic        as;
        logic [1:0]  eo;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             vec[$];
    exp_t             e;
    int               n_vec = 0;
    int               n_miss = 0;
    bit               mon_en = 1'b0;
    int               cyc = 0;
    int               last_fetch = 0;
    logic [CNT_W-1:0] exp_ret = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(logic [31:0] i, logic z, int lat, logic [1:0] npc, logic rw,
                                logic [1:0] rd, logic [1:0] wd, logic mw, logic il,
                                logic [1:0] ao, logic ao_dc, logic as, logic [1:0] eo);
        exp_t r;
        r.inst = i; r.z = z; r.lat = lat; r.npc = npc; r.rw = rw; r.rd = rd; r.wd = wd;
        r.mw = mw; r.il = il; r.ao = ao; r.ao_dc = ao_dc; r.as = as; r.eo = eo;
        return r;
    endfunction

    // Monitor: invariants every cycle, scoreboard pop on every PC update.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            check("strobe_invariants",
                  {29'd0, pc_we & ir_we, ~pc_we & (npc_sel != IFU_SEL_NORM),
                   ~pc_we & (reg_we | mem_we | illegal)}, 32'd0);
            if (ir_we) last_fetch = cyc;
            if (pc_we) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pc_we", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("ir",       ir,               e.inst);
                    check("latency",  cyc - last_fetch, e.lat);
                    check("npc_sel",  npc_sel,          e.npc);
                    check("reg_we",   reg_we,           e.rw);
                    check("reg_dst",  reg_dst,          e.rd);
                    check("wd_sel",   wd_sel,           e.wd);
                    check("mem_we",   mem_we,           e.mw);
                    check("illegal",  illegal,          e.il);
                    if (!e.ao_dc) check("alu_op", alu_op, e.ao);
                    check("alu_src",  alu_src,          e.as);
                    check("ext_op",   ext_op,           e.eo);
                    check("retired",  retired,          exp_ret);
                    exp_ret = exp_ret + 1'b1;
                end
            end
        end
    end

    // Present the next instruction while the DUT is in FETCH and queue its expectation.
    task automatic issue(input exp_t v, input bit now);
        bit got;
        got = now;
        for (int t = 0; t < 12 && !got; t++) begin
            @(negedge clk);
            #1;
            if (ir_we === 1'b1) got = 1'b1;
        end
        if (!got) check("fetch_timeout", 32'd0, 32'd1);
        inst = v.inst;
        zero = v.z;
        sb_q.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inst  = 32'h0;
        zero  = 1'b0;

        vec.push_back(mk(32'h00221821, 1, 3, IFU_SEL_NORM, 1, REG_DST_RD, WD_SEL_ALU, 0, 0, ALU_OP_ADD, 0, 0, EXT_ZERO));
        vec.push_back(mk(32'h10220004, 1, 2, IFU_SEL_RELATIVE, 0, REG_DST_RT, WD_SEL_ALU, 0, 0, ALU_OP_SUB, 0, 0, EXT_ZERO));
        vec.push_back(mk(32'h10220004, 0, 2, IFU_SEL_NORM, 0, REG_DST_RT, WD_SEL_ALU, 0, 0, ALU_OP_SUB, 0, 0, EXT_ZERO));
        vec.push_back(mk(32'h0C001234, 0, 1, IFU_SEL_IRRELATIVE, 1, REG_DST_RA, WD_SEL_PC4, 0, 0, ALU_OP_ADD, 0, 0, EXT_ZERO));
        vec.push_back(mk(32'h8C280004, 1, 4, IFU_SEL_NORM, 1, REG_DST_RT, WD_SEL_MEM, 0, 0, ALU_OP_ADD, 0, 1, EXT_SIGN));
        vec.push_back(mk(32'hAC280008, 0, 3, IFU_SEL_NORM, 0, REG_DST_RT, WD_SEL_ALU, 1, 0, ALU_OP_ADD, 0, 1, EXT_SIGN));
        vec.push_back(mk(32'hFC000000, 1, 1, IFU_SEL_NORM, 0, REG_DST_RT, WD_SEL_ALU, 0, 1, ALU_OP_ADD, 0, 0, EXT_ZERO));
        vec.push_back(mk(32'h00221823, 0, 3, IFU_SEL_NORM, 1, REG_DST_RD, WD_SEL_ALU, 0, 0, ALU_OP_SUB, 0, 0, EXT_ZERO));
        vec.push_back(mk(32'h342500FF, 0, 3, IFU_SEL_NORM, 1, REG_DST_RT, WD_SEL_ALU, 0, 0, ALU_OP_OR, 0, 1, EXT_ZERO));
        vec.push_back(mk(32'h3C061234, 0, 3, IFU_SEL_NORM, 1, REG_DST_RT, WD_SEL_ALU, 0, 0, ALU_OP_ADD, 1, 1, EXT_LUI));
        vec.push_back(mk(32'h03E00008, 1, 1, IFU_SEL_REGISTER, 0, REG_DST_RT, WD_SEL_ALU, 0, 0, ALU_OP_ADD, 0, 0, EXT_ZERO));
        vec.push_back(mk(32'h0000003F, 0, 1, IFU_SEL_NORM, 0, REG_DST_RT, WD_SEL_ALU, 0, 1, ALU_OP_ADD, 0, 0, EXT_ZERO));
        for (int k = 0; k < 7; k++)
            vec.push_back(mk(32'h08000010 + k, k[0], 1, IFU_SEL_IRRELATIVE, 0, REG_DST_RT, WD_SEL_ALU, 0, 0, ALU_OP_ADD, 0, 0, EXT_ZERO));

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_state",   state_o, S_FETCH);
        check("rst_retired", retired, 32'd0);
        check("rst_ir",      ir,      32'd0);
        check("rst_strobes", {ir_we, pc_we, reg_we, mem_we, illegal}, 32'd0);
        check("rst_selects", {npc_sel, reg_dst, wd_sel, alu_src, ext_op, alu_op}, 32'd0);

        // Retire one j, then abandon a lw in MEM with a 2-cycle reset.
        reset = 1'b0;
        inst  = 32'h08000004;
        @(negedge clk); #1;
        check("pre_j_pc_we", {pc_we, npc_sel}, {1'b1, IFU_SEL_IRRELATIVE});
        @(negedge clk); #1;
        inst = 32'h8C280004;
        repeat (3) @(negedge clk);
        #1;
        check("pre_lw_state",   state_o, S_MEM);
        check("pre_lw_retired", retired, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_strobes", {pc_we, reg_we, mem_we}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            check("rst_mid_state",   state_o, S_FETCH);
            check("rst_mid_retired", retired, 32'd0);
            check("rst_mid_reg_we",  reg_we,  32'd0);
        end
        reset = 1'b0;
        #1;

        // Scoreboarded instruction stream.
        mon_en     = 1'b1;
        last_fetch = cyc;
        issue(vec[0], 1'b1);
        for (int k = 1; k < vec.size(); k++) issue(vec[k], 1'b0);

        begin
            bit drained;
            drained = 1'b0;
            for (int t = 0; t < 30 && !drained; t++) begin
                @(negedge clk); #1;
                if (sb_q.size() == 0) drained = 1'b1;
            end
            if (!drained) check("drain_timeout", sb_q.size(), 32'd0);
        end
        @(negedge clk); #1;
        mon_en = 1'b0;
        check("retired_wrap", retired, 32'(vec.size() % (1 << CNT_W)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
